// File: rtl/fp_accum.sv
// IEEE-754 single-precision accumulator: IDLE -> ALIGN -> ADD -> NORM -> DONE.
// Guard bits are carried through the datapath and truncated on pack (round toward zero).
module fp_accum #(
  parameter int unsigned GUARD_BITS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        acc_start,
  input  logic [31:0] in_data,
  input  logic        in_overflow,
  input  logic        acc_clear,
  output logic        acc_ready,
  output logic        acc_busy,
  output logic        acc_done,
  output logic [31:0] acc_result,
  output logic        acc_overflow
);
  localparam int unsigned W = 24 + GUARD_BITS;

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_DONE} state_e;
  typedef enum logic [1:0] {M_ARITH, M_KEEP, M_INF} mode_e;

  state_e       state_q, state_d;
  mode_e        mode_q, mode_d;
  logic [31:0]  op_q, res_q, res_d;
  logic         opovf_q, ovf_q, ovf_d;
  logic         sa_q, sb_q, sa_d, sb_d;
  logic [7:0]   ea_q, ea_d;
  logic [W-1:0] ma_q, mb_q, ma_d, mb_d;
  logic [W:0]   sum_q, sum_d;

  // ALIGN: flush denormals, order by magnitude, shift the smaller operand
  logic [30:0]  mag_acc, mag_op;
  logic [31:0]  hi, lo;
  logic [7:0]   eb, diff;
  logic [W-1:0] mb_raw;
  always_comb begin
    mag_acc = (res_q[30:23] == 8'd0) ? '0 : res_q[30:0];
    mag_op  = (op_q[30:23] == 8'd0) ? '0 : op_q[30:0];
    if (mag_op > mag_acc) begin
      hi = {op_q[31], mag_op};
      lo = {res_q[31], mag_acc};
    end else begin
      hi = {res_q[31], mag_acc};
      lo = {op_q[31], mag_op};
    end
    sa_d   = hi[31];
    sb_d   = lo[31];
    ea_d   = hi[30:23];
    eb     = lo[30:23];
    diff   = ea_d - eb;
    ma_d   = (ea_d != 8'd0) ? {1'b1, hi[22:0], {GUARD_BITS{1'b0}}} : '0;
    mb_raw = (eb != 8'd0) ? {1'b1, lo[22:0], {GUARD_BITS{1'b0}}} : '0;
    mb_d   = (32'(diff) > W) ? '0 : (mb_raw >> diff);
    if (res_q[30:23] == 8'hFF)
      mode_d = M_KEEP;
    else if (opovf_q || op_q[30:23] == 8'hFF)
      mode_d = M_INF;
    else
      mode_d = M_ARITH;
  end

  // ADD: A >= B in magnitude, so subtraction never goes negative
  always_comb begin
    if (sa_q == sb_q)
      sum_d = {1'b0, ma_q} + {1'b0, mb_q};
    else
      sum_d = {1'b0, ma_q} - {1'b0, mb_q};
  end

  // NORM: carry or leading-zero normalise, then pack with range checks
  int unsigned  lz;
  logic [W-1:0] nm;
  logic [9:0]   ne;
  always_comb begin
    lz = 0;
    for (int unsigned i = 0; i < W; i++)
      if (sum_q[i]) lz = W - 1 - i;
    if (sum_q[W]) begin
      nm = sum_q[W:1];
      ne = {2'b00, ea_q} + 10'd1;
    end else begin
      nm = sum_q[W-1:0] << lz;
      ne = {2'b00, ea_q} - 10'(lz);
    end
    res_d = res_q;
    ovf_d = ovf_q;
    case (mode_q)
      M_KEEP: ;
      M_INF: begin
        res_d = {op_q[31], 8'hFF, 23'd0};
        ovf_d = 1'b1;
      end
      default: begin
        if (sum_q == '0 || ne[9] || ne == 10'd0)
          res_d = '0;
        else if (ne >= 10'd255) begin
          res_d = {sa_q, 8'hFF, 23'd0};
          ovf_d = 1'b1;
        end else
          res_d = {sa_q, ne[7:0], nm[W-2 -: 23]};
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (acc_start && !acc_clear) state_d = S_ALIGN;
      S_ALIGN: state_d = S_ADD;
      S_ADD:   state_d = S_NORM;
      S_NORM:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || acc_clear) begin
      state_q <= S_IDLE;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      op_q    <= '0;
      opovf_q <= 1'b0;
      mode_q  <= M_ARITH;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      ea_q    <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (acc_start) begin
          op_q    <= in_data;
          opovf_q <= in_overflow;
        end
        S_ALIGN: begin
          mode_q <= mode_d;
          sa_q   <= sa_d;
          sb_q   <= sb_d;
          ea_q   <= ea_d;
          ma_q   <= ma_d;
          mb_q   <= mb_d;
        end
        S_ADD:  sum_q <= sum_d;
        S_NORM: begin
          res_q <= res_d;
          ovf_q <= ovf_d;
        end
        default: ;
      endcase
    end
  end

  assign acc_ready    = (state_q == S_IDLE);
  assign acc_busy     = (state_q != S_IDLE);
  assign acc_done     = (state_q == S_DONE);
  assign acc_result   = res_q;
  assign acc_overflow = ovf_q;
endmodule

// File: tb/tb_fp_accum.sv
// Directed self-checking bench for fp_accum with hand-computed IEEE-754 sums.
module tb_fp_accum;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        acc_start = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_overflow = 1'b0;
  logic        acc_clear = 1'b0;
  logic        acc_ready, acc_busy, acc_done, acc_overflow;
  logic [31:0] acc_result;

  int errors = 0;
  int checks = 0;

  fp_accum #(.GUARD_BITS(3)) dut (
    .clk(clk), .rst(rst), .acc_start(acc_start), .in_data(in_data),
    .in_overflow(in_overflow), .acc_clear(acc_clear), .acc_ready(acc_ready),
    .acc_busy(acc_busy), .acc_done(acc_done), .acc_result(acc_result),
    .acc_overflow(acc_overflow)
  );

  always #5 clk = ~clk;

  // Pulse acc_start for one cycle and count cycles to acc_done (99 = timeout)
  task automatic do_add(input logic [31:0] d, input logic ovf, output int lat, output int busy_cnt);
    @(negedge clk);
    acc_start = 1'b1; in_data = d; in_overflow = ovf;
    @(negedge clk);
    acc_start = 1'b0; in_overflow = 1'b0;
    lat = 1; busy_cnt = 0;
    while (!acc_done && lat < 12) begin
      if (acc_busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    if (acc_busy) busy_cnt++;
    if (!acc_done) lat = 99;
    @(negedge clk);
  endtask

  task automatic do_clear();
    @(negedge clk); acc_clear = 1'b1;
    @(negedge clk); acc_clear = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk); rst = 1'b0;
    checks++; if (acc_result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=00000000", acc_result); end
    checks++; if ({acc_overflow, acc_done, acc_busy, acc_ready} !== 4'b0001) begin errors++;
      $display("FAIL reset_flags got=%b exp=0001", {acc_overflow, acc_done, acc_busy, acc_ready}); end
    do_clear();
  endtask

  task automatic test_basic();
    int lat, bc;
    do_add(32'h3FC00000, 1'b0, lat, bc);
    checks++; if (lat !== 4) begin errors++; $display("FAIL latency got=%0d exp=4", lat); end
    checks++; if (bc !== 4) begin errors++; $display("FAIL busy_cycles got=%0d exp=4", bc); end
    checks++; if (acc_result !== 32'h3FC00000) begin errors++; $display("FAIL add_1p5 got=%h exp=3fc00000", acc_result); end
    checks++; if (acc_ready !== 1'b1 || acc_busy !== 1'b0) begin errors++; $display("FAIL idle_after got=%b%b exp=10", acc_ready, acc_busy); end
    do_add(32'h3FF00000, 1'b0, lat, bc);
    checks++; if (acc_result !== 32'h40580000) begin errors++; $display("FAIL add_3p375 got=%h exp=40580000", acc_result); end
    do_add(32'hC0580000, 1'b0, lat, bc);
    checks++; if (acc_result !== 32'h00000000) begin errors++; $display("FAIL cancel_zero got=%h exp=00000000", acc_result); end
  endtask

  task automatic test_busy_ignore();
    int lat, bc, extra;
    do_clear();
    do_add(32'h40C00000, 1'b0, lat, bc);
    @(negedge clk);
    acc_start = 1'b1; in_data = 32'hBF800000;
    @(negedge clk);
    in_data = 32'h42C80000;
    @(negedge clk);
    acc_start = 1'b0;
    lat = 0;
    while (!acc_done && lat < 12) begin @(negedge clk); lat++; end
    checks++; if (acc_result !== 32'h40A00000) begin errors++; $display("FAIL sub_5p0 got=%h exp=40a00000", acc_result); end
    extra = 0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (acc_done) extra++; end
    checks++; if (extra !== 0) begin errors++; $display("FAIL busy_ignored got=%0d extra done exp=0", extra); end
    checks++; if (acc_result !== 32'h40A00000) begin errors++; $display("FAIL busy_result got=%h exp=40a00000", acc_result); end
  endtask

  task automatic test_truncate();
    int lat, bc;
    do_clear();
    do_add(32'h4B800000, 1'b0, lat, bc);
    do_add(32'h3F800000, 1'b0, lat, bc);
    checks++; if (acc_result !== 32'h4B800000) begin errors++; $display("FAIL truncate got=%h exp=4b800000", acc_result); end
  endtask

  task automatic test_overflow();
    int lat, bc;
    do_clear();
    do_add(32'h7F7FFFFF, 1'b0, lat, bc);
    checks++; if (acc_overflow !== 1'b0) begin errors++; $display("FAIL max_no_ovf got=%b exp=0", acc_overflow); end
    do_add(32'h7F7FFFFF, 1'b0, lat, bc);
    checks++; if (acc_result !== 32'h7F800000) begin errors++; $display("FAIL ovf_inf got=%h exp=7f800000", acc_result); end
    checks++; if (acc_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", acc_overflow); end
    do_add(32'h3F800000, 1'b0, lat, bc);
    checks++; if (acc_result !== 32'h7F800000 || acc_overflow !== 1'b1) begin errors++;
      $display("FAIL inf_sticky got=%h/%b exp=7f800000/1", acc_result, acc_overflow); end
    do_add(32'hFF800000, 1'b0, lat, bc);
    checks++; if (acc_result !== 32'h7F800000) begin errors++; $display("FAIL inf_opposite got=%h exp=7f800000", acc_result); end
    do_clear();
    checks++; if (acc_result !== 32'h0 || acc_overflow !== 1'b0) begin errors++;
      $display("FAIL clear got=%h/%b exp=00000000/0", acc_result, acc_overflow); end
  endtask

  task automatic test_clear_start();
    @(negedge clk); acc_clear = 1'b1; acc_start = 1'b1; in_data = 32'h3F800000;
    @(negedge clk); acc_clear = 1'b0; acc_start = 1'b0;
    checks++; if (acc_busy !== 1'b0) begin errors++; $display("FAIL clear_drops_start got=%b exp=0", acc_busy); end
  endtask

  task automatic test_in_overflow_and_reset();
    int lat, bc, dn;
    do_add(32'hC1000000, 1'b1, lat, bc);
    checks++; if (lat !== 4) begin errors++; $display("FAIL ovf_in_latency got=%0d exp=4", lat); end
    checks++; if (acc_result !== 32'hFF800000 || acc_overflow !== 1'b1) begin errors++;
      $display("FAIL ovf_in got=%h/%b exp=ff800000/1", acc_result, acc_overflow); end
    @(negedge clk); acc_start = 1'b1; in_data = 32'h3F800000;
    @(negedge clk); acc_start = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checks++; if (acc_result !== 32'h0) begin errors++; $display("FAIL rst_mid_result got=%h exp=00000000", acc_result); end
    checks++; if ({acc_overflow, acc_done, acc_busy, acc_ready} !== 4'b0001) begin errors++;
      $display("FAIL rst_mid_flags got=%b exp=0001", {acc_overflow, acc_done, acc_busy, acc_ready}); end
    dn = 0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (acc_done) dn++; end
    checks++; if (dn !== 0) begin errors++; $display("FAIL rst_no_done got=%0d exp=0", dn); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_busy_ignore();
    test_truncate();
    test_overflow();
    test_clear_start();
    test_in_overflow_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fp_accum.md
Name: fp_accum

Overview:
- Multi-cycle IEEE-754 single-precision accumulator that sits directly downstream of the floating-point multiplier.
- Each product the multiplier reports done is added into a running 32-bit sum; the sum is held until cleared.
- Forms the add half of the multiply-accumulate datapath.
- Uses the same start/done/busy handshake style as the multiplier.

Parameters:
- GUARD_BITS, 3: extra low-order mantissa bits carried through align/add/normalise. The result is then truncated (round toward zero).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- acc_start  in  1  one-cycle pulse: add in_data to accumulator. Driven from multiplier mul_done.
- in_data  in  32  operand (multiplier mul_result).
- in_overflow  in  1  multiplier overflow flag, sampled with acc_start.
- acc_clear  in  1  synchronous clear of accumulator and sticky flag.
- acc_ready  out  1  high only in IDLE; acc_start ignored when low.
- acc_busy  out  1  high in any state other than IDLE.
- acc_done  out  1  one-cycle pulse when acc_result updated.
- acc_result  out  32  current accumulated sum.
- acc_overflow  out  1  sticky overflow flag.

Behaviour:
Reset (rst high at a clock edge):
- acc_result=0x00000000, acc_overflow=0, acc_done=0, acc_busy=0, acc_ready=1, state=IDLE.
- Reset mid-operation aborts the add, with no done pulse.

FSM: IDLE -> ALIGN -> ADD -> NORM -> DONE -> IDLE. One cycle per state.
- IDLE:
  - acc_start && !acc_clear registers in_data and in_overflow, then goes to ALIGN.
- ALIGN:
  - Unpack both operands; hidden bit = 1 when exp != 0.
  - exp==0 is treated as zero (denormals flushed).
  - Swap so the larger magnitude is operand A.
  - Right-shift the B mantissa by the exponent difference into a 24+GUARD_BITS field. A difference > 24+GUARD_BITS gives B = 0.
- ADD:
  - Same signs: add magnitudes. Different signs: subtract B from A.
  - Result sign = sign of A.
  - 1-bit carry-out field kept.
- NORM:
  - Carry set: shift right 1, exp+1.
  - Otherwise: single-cycle leading-zero count, shift left, exp-LZC.
  - Zero magnitude, or exp underflow (<=0): result +0 (0x00000000).
  - Exp >= 255: result = signed infinity (exp 255, mantissa 0); set acc_overflow.
  - Drop guard bits by truncation.
- DONE:
  - acc_result updated; acc_done=1 for exactly this cycle; then IDLE.

Latency and throughput:
- acc_start at cycle N gives acc_done and the new acc_result at cycle N+4.
- Next acc_start accepted at N+5; throughput is one add per 5 cycles.

Special cases:
- in_overflow=1 or in_data exp==255: skip the arithmetic. Accumulator = infinity with in_data sign; acc_overflow=1. Done still pulses at N+4.
- Accumulator already infinite: a finite operand leaves it unchanged. Infinity of opposite sign also leaves it unchanged; flag stays set.

acc_clear:
- Highest priority after rst.
- In any state, the next cycle gives acc_result=0, acc_overflow=0, state=IDLE, with no done pulse.
- acc_start in the same cycle as acc_clear is dropped.

acc_result is stable at all times except the DONE update cycle.

Test Plan:
- Reset then clear; acc_start in_data=0x3FC00000 (1.5) -> acc_done at +4 cycles, acc_result=0x3FC00000; acc_busy high for 4 cycles.
- Continuing: acc_start 0x3FF00000 (1.875) -> 0x40580000 (3.375); then acc_start 0xC0580000 (-3.375) -> 0x00000000.
- Clear; add 0x40C00000 (6.0), then 0xBF800000 (-1.0) -> 0x40A00000 (5.0). acc_start pulsed while busy is ignored (result unchanged).
- Clear; add 0x4B800000 (2^24), then 0x3F800000 (1.0) -> 0x4B800000 (truncation drops the bit).
- Clear; add 0x7F7FFFFF twice -> 0x7F800000, acc_overflow=1. Then add 0x3F800000 -> unchanged, flag sticky. acc_clear -> 0x00000000, flag 0.
- acc_start with in_overflow=1, in_data=0xC1000000 -> 0xFF800000, acc_overflow=1. Assert rst in the ALIGN cycle of a new add -> no acc_done, all outputs at reset values next cycle.
